// File: rtl/prog_clk_div.sv
// prog_clk_div: NUM_CH independent programmable clock dividers.
// Each channel has a period counter and a double-buffered (shadow -> active)
// divisor/high-count pair. The active pair changes only at a period boundary
// or while the channel is disabled, so output period and duty never glitch.
// Optional feature macro: CLKDIV_SYNC_EN adds the 'sync' input, which restarts
// every enabled channel at cnt=0 and applies its pending shadow config.
module prog_clk_div #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 12,
    parameter int DEF_DIV  = 1,
    parameter int DEF_HIGH = 1,
    localparam int LD_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              ld,
    input  logic [LD_W-1:0]   ld_ch,
    input  logic [DIV_W-1:0]  ld_div,
    input  logic [DIV_W-1:0]  ld_high,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);

    typedef struct packed {
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] act_high;
        logic [DIV_W-1:0] sh_div;
        logic [DIV_W-1:0] sh_high;
        logic             pend;
        logic             div;
        logic             tick;
    } ch_t;

    ch_t               ch_q [NUM_CH];
    ch_t               ch_d [NUM_CH];
    logic              sync_i;
    logic [NUM_CH-1:0] ld_hit;
    logic [NUM_CH-1:0] apply;

`ifdef CLKDIV_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    // Per-channel next state: count step, output levels, shadow apply, config write.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        ld_hit = '0;
        apply  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i] = ch_q[i];
            // Out-of-range channel numbers match no index and are dropped.
            ld_hit[i] = ld && (32'(ld_ch) == i);
            // Period boundary (or idle / sync): counter restarts, shadow becomes active.
            apply[i] = !en[i] || sync_i || (ch_q[i].cnt == ch_q[i].act_div);

            // Outputs reflect the current count against the still-active config.
            ch_d[i].tick = en[i] && (ch_q[i].cnt == '0);
            ch_d[i].div  = en[i] && (ch_q[i].cnt < ch_q[i].act_high);
            ch_d[i].cnt  = apply[i] ? '0 : ch_q[i].cnt + DIV_W'(1);

            if (apply[i]) begin
                ch_d[i].act_div  = ch_q[i].sh_div;
                ch_d[i].act_high = ch_q[i].sh_high;
                ch_d[i].pend     = 1'b0;
            end
            // A write on the apply edge lands in the shadow after the old shadow moved on.
            if (ld_hit[i]) begin
                ch_d[i].sh_div  = ld_div;
                ch_d[i].sh_high = ld_high;
                ch_d[i].pend    = 1'b1;
            end
        end
    end

    // Channel state registers; reset restores the default config everywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this per-channel array is small and its reset value is visible at the outputs, so every entry is reset (unlike a RAM).
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i].cnt      <= '0;
                ch_q[i].act_div  <= DIV_W'(DEF_DIV);
                ch_q[i].act_high <= DIV_W'(DEF_HIGH);
                ch_q[i].sh_div   <= DIV_W'(DEF_DIV);
                ch_q[i].sh_high  <= DIV_W'(DEF_HIGH);
                ch_q[i].pend     <= 1'b0;
                ch_q[i].div      <= 1'b0;
                ch_q[i].tick     <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignment so every channel updates from pre-edge state.
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    // Outputs come straight from flops; no input-to-output combinational path.
    always_comb begin
        pend    = '0;
        div_out = '0;
        tick    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend[i]    = ch_q[i].pend;
            div_out[i] = ch_q[i].div;
            tick[i]    = ch_q[i].tick;
        end
    end

endmodule
